// File: rtl/enemy_motion.sv
// enemy_motion: per-frame walk/turn/stun controller for the left-side enemy sprite (ports: clk, rst, h_cnt, v_cnt, enable, hit -> pos_x, pos_y, facing_left, anim_frame, stunned, frame_tick)
module enemy_motion #(
  parameter int SPRITE_W    = 32,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 608,
  parameter int Y_POS       = 400,
  parameter int START_X     = 0,
  parameter int SPEED       = 2,
  parameter int ANIM_DIV    = 8,
  parameter int TURN_FRAMES = 16,
  parameter int STUN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  input  logic       enable,
  input  logic       hit,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       facing_left,
  output logic [1:0] anim_frame,
  output logic       stunned,
  output logic       frame_tick
);
  typedef enum logic [1:0] {WALK_R, WALK_L, TURN, STUN} state_t;
  state_t      state_q, state_d;
  logic [9:0]  pos_x_q, pos_x_d, pos_y_q;
  logic        facing_q, facing_d, stunned_q, stunned_d;
  logic [1:0]  anim_frame_q, anim_frame_d;
  logic [15:0] anim_cnt_q, anim_cnt_d, turn_cnt_q, turn_cnt_d, stun_cnt_q, stun_cnt_d;
  logic        cond, cond_q, frame_tick_q, step, anim_wrap;
  logic [10:0] sum;
  assign cond      = (v_cnt == 10'd480) && (h_cnt == 10'd0);
  assign step      = frame_tick_q & enable;
  assign sum       = {1'b0, pos_x_q} + 11'(SPEED);
  assign anim_wrap = anim_cnt_q == 16'(ANIM_DIV - 1);
  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    facing_d     = facing_q;
    stunned_d    = stunned_q;
    anim_frame_d = anim_frame_q;
    anim_cnt_d   = anim_cnt_q;
    turn_cnt_d   = turn_cnt_q;
    stun_cnt_d   = stun_cnt_q;
    if (hit) begin
      state_d      = STUN;
      stun_cnt_d   = '0;
      stunned_d    = 1'b1;
      anim_frame_d = '0;
    end else if (step) begin
      case (state_q)
        WALK_R, WALK_L: begin
          anim_cnt_d   = anim_wrap ? '0 : anim_cnt_q + 16'd1;
          anim_frame_d = anim_wrap ? anim_frame_q + 2'd1 : anim_frame_q;
          if (state_q == WALK_R ? sum >= 11'(X_MAX) : {1'b0, pos_x_q} <= 11'(X_MIN + SPEED)) begin
            pos_x_d      = state_q == WALK_R ? 10'(X_MAX) : 10'(X_MIN);
            state_d      = TURN;
            turn_cnt_d   = '0;
            anim_cnt_d   = '0;
            anim_frame_d = '0;
          end else
            pos_x_d = state_q == WALK_R ? sum[9:0] : pos_x_q - 10'(SPEED);
        end
        TURN: begin
          anim_cnt_d   = '0;
          anim_frame_d = '0;
          turn_cnt_d   = turn_cnt_q + 16'd1;
          if (turn_cnt_q == 16'(TURN_FRAMES - 1)) begin
            facing_d = ~facing_q;
            state_d  = facing_q ? WALK_R : WALK_L;
          end
        end
        default: begin
          stun_cnt_d = stun_cnt_q + 16'd1;
          if (stun_cnt_q == 16'(STUN_FRAMES - 1)) begin
            stunned_d = 1'b0;
            state_d   = facing_q ? WALK_L : WALK_R;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WALK_R;
      pos_x_q      <= 10'(START_X);
      pos_y_q      <= 10'(Y_POS);
      facing_q     <= 1'b0;
      stunned_q    <= 1'b0;
      anim_frame_q <= '0;
      anim_cnt_q   <= '0;
      turn_cnt_q   <= '0;
      stun_cnt_q   <= '0;
      cond_q       <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= 10'(Y_POS);
      facing_q     <= facing_d;
      stunned_q    <= stunned_d;
      anim_frame_q <= anim_frame_d;
      anim_cnt_q   <= anim_cnt_d;
      turn_cnt_q   <= turn_cnt_d;
      stun_cnt_q   <= stun_cnt_d;
      cond_q       <= cond;
      frame_tick_q <= cond & ~cond_q;
    end
  end
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign facing_left = facing_q;
  assign anim_frame  = anim_frame_q;
  assign stunned     = stunned_q;
  assign frame_tick  = frame_tick_q;
endmodule

// File: tb/tb_enemy_motion.sv
// tb_enemy_motion: directed self-checking bench for enemy_motion
module tb_enemy_motion;
  logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, hit = 1'b0;
  logic [9:0] h_cnt = 10'd5, v_cnt = 10'd0;
  logic [9:0] pos_x, pos_y, pos_x2, pos_y2;
  logic       facing_left, stunned, frame_tick, facing_left2, stunned2, frame_tick2;
  logic [1:0] anim_frame, anim_frame2;
  int checks = 0, failures = 0, ft_seen = 0, ft_base;
  always #5 clk = ~clk;
  enemy_motion dut (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .enable(enable), .hit(hit),
    .pos_x(pos_x), .pos_y(pos_y), .facing_left(facing_left), .anim_frame(anim_frame),
    .stunned(stunned), .frame_tick(frame_tick)
  );
  enemy_motion #(.START_X(604)) dut2 (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .enable(enable), .hit(hit),
    .pos_x(pos_x2), .pos_y(pos_y2), .facing_left(facing_left2), .anim_frame(anim_frame2),
    .stunned(stunned2), .frame_tick(frame_tick2)
  );
  always @(negedge clk) ft_seen += int'(frame_tick);
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic frame(input logic hit_on_tick = 1'b0);
    @(negedge clk);
    v_cnt = 10'd480;
    h_cnt = 10'd0;
    @(negedge clk);
    hit = hit_on_tick;
    @(negedge clk);
    hit = 1'b0;
    repeat (2) @(negedge clk);
    v_cnt = 10'd0;
    h_cnt = 10'd5;
    repeat (4) @(negedge clk);
  endtask
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask
  task automatic pulse_hit;
    @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pos_x", pos_x, 0);
    chk("rst_pos_y", pos_y, 400);
    chk("rst_facing", facing_left, 0);
    chk("rst_anim", anim_frame, 0);
    chk("rst_stunned", stunned, 0);
    chk("rst_frame_tick", frame_tick, 0);
    chk("rst_pos_x2", pos_x2, 604);
    rst = 1'b0;
    enable = 1'b1;
    ft_base = ft_seen;
    frame();
    chk("t1_ft_once", ft_seen - ft_base, 1);
    chk("t1_pos_x", pos_x, 2);
    chk("t1_pos_x2", pos_x2, 606);
    frame();
    chk("t2_pos_x", pos_x, 4);
    chk("t2_pos_x2_edge", pos_x2, 608);
    frame();
    chk("t3_pos_x", pos_x, 6);
    chk("t3_facing", facing_left, 0);
    chk("t3_ft_count", ft_seen - ft_base, 3);
    chk("t3_anim2_turn", anim_frame2, 0);
    frames(4);
    chk("t7_anim", anim_frame, 0);
    frame();
    chk("t8_anim_step", anim_frame, 1);
    chk("t8_pos_x", pos_x, 16);
    frames(9);
    chk("t17_pos_x2_held", pos_x2, 608);
    chk("t17_facing2", facing_left2, 0);
    chk("t17_anim2", anim_frame2, 0);
    frame();
    chk("t18_facing2", facing_left2, 1);
    chk("t18_anim", anim_frame, 2);
    frame();
    chk("t19_pos_x2_left", pos_x2, 606);
    frames(12);
    chk("t31_anim", anim_frame, 3);
    frame();
    chk("t32_anim_wrap", anim_frame, 0);
    chk("t32_pos_x", pos_x, 64);
    frames(18);
    chk("t50_pos_x", pos_x, 100);
    chk("t50_pos_x2", pos_x2, 544);
    chk("t50_anim", anim_frame, 2);
    pulse_hit();
    chk("hit_stunned_next", stunned, 1);
    chk("hit_anim_zero", anim_frame, 0);
    chk("hit_facing2_kept", facing_left2, 1);
    frames(30);
    chk("stun30_pos_x", pos_x, 100);
    pulse_hit();
    frames(59);
    chk("stun89_still", stunned, 1);
    chk("stun89_pos_x", pos_x, 100);
    frame();
    chk("stun90_released", stunned, 0);
    chk("stun90_pos_x", pos_x, 100);
    frame();
    chk("resume_pos_x", pos_x, 102);
    chk("resume_pos_x2", pos_x2, 542);
    chk("resume_facing", facing_left, 0);
    frame(1'b1);
    chk("hit_tick_pos_x", pos_x, 102);
    chk("hit_tick_stunned", stunned, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frames(9);
    chk("turn7_pos_x2", pos_x2, 608);
    chk("turn7_facing2", facing_left2, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_turn_pos_x2", pos_x2, 604);
    chk("rst_turn_facing2", facing_left2, 0);
    chk("rst_turn_anim2", anim_frame2, 0);
    chk("rst_turn_stunned2", stunned2, 0);
    enable = 1'b0;
    ft_base = ft_seen;
    frames(5);
    chk("dis_ft_count", ft_seen - ft_base, 5);
    chk("dis_pos_x2", pos_x2, 604);
    chk("dis_pos_x", pos_x, 0);
    enable = 1'b1;
    frame();
    chk("en_walk_r_x2", pos_x2, 606);
    chk("en_walk_r_x", pos_x, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/enemy_motion.md
Name: enemy_motion

Overview:
- Per-frame motion and animation controller for the left-side enemy sprite.
- Sits directly upstream of the enemy sprite renderer and supplies its screen position, facing direction and animation frame index.
- Derives a one-per-frame update tick from the VGA scan counters.
- Walks the sprite horizontally between screen limits, pauses to turn at each edge, and freezes for a stun period when a hit is reported.

Parameters:
- SPRITE_W, 32: sprite width in pixels.
- X_MIN, 0: leftmost allowed pos_x.
- X_MAX, 608: rightmost allowed pos_x (640 - SPRITE_W).
- Y_POS, 400: fixed vertical position output on pos_y.
- START_X, 0: pos_x after reset.
- SPEED, 2: pixels moved per frame tick while walking. Constraint: 1..15.
- ANIM_DIV, 8: frame ticks per animation step. Constraint: ≥1.
- TURN_FRAMES, 16: frame ticks spent in the turn pause. Constraint: ≥1.
- STUN_FRAMES, 60: frame ticks spent stunned. Constraint: ≥1.

Ports:
- clk  in  1  system clock (100 MHz). The only clock.
- rst  in  1  synchronous, active-high reset.
- h_cnt  in  10  VGA horizontal counter (pixel-clock domain, stable for several clk cycles per value).
- v_cnt  in  10  VGA vertical counter.
- enable  in  1  when low, frame ticks are ignored; all state and counters hold.
- hit  in  1  single-cycle or level hit indication from collision logic.
- pos_x  out  10  sprite left edge, registered.
- pos_y  out  10  sprite top edge, registered, constant Y_POS.
- facing_left  out  1  1 = sprite faces/moves left.
- anim_frame  out  2  walk animation index 0..3.
- stunned  out  1  high while in STUN.
- frame_tick  out  1  one-clk pulse at the start of vertical blanking.

Behaviour:
- Reset: applied on any clk edge with rst=1, including mid-turn or mid-stun.
  - Outputs: pos_x=START_X, pos_y=Y_POS, facing_left=0, anim_frame=0, stunned=0, frame_tick=0.
  - Internal: state=WALK_R, anim/turn/stun counters=0, tick-edge register=0.
- Frame tick generation:
  - cond = (v_cnt==480 && h_cnt==0); cond_q is cond registered on clk.
  - frame_tick = cond & ~cond_q, registered. Exactly one clk pulse per frame, even though cond is held for 4 clk cycles.
  - frame_tick is generated regardless of enable. All state updates below act on frame_tick only when enable=1.
- States: WALK_R, WALK_L, TURN, STUN. Updates happen on the clk edge where frame_tick=1, unless stated otherwise.
- WALK_R:
  - Compute sum = pos_x + SPEED at 11 bits (no wrap).
  - If sum >= X_MAX: pos_x=X_MAX, go to TURN, turn_cnt=0.
  - Otherwise: pos_x = sum[9:0].
- WALK_L:
  - If pos_x <= X_MIN + SPEED: pos_x=X_MIN, go to TURN, turn_cnt=0.
  - Otherwise: pos_x = pos_x - SPEED. Never underflows.
- Animation in WALK_R/WALK_L, per tick:
  - anim_cnt increments.
  - When anim_cnt == ANIM_DIV-1: anim_cnt=0 and anim_frame = anim_frame+1 mod 4 (3 wraps to 0).
- TURN:
  - pos_x frozen; anim_frame=0; anim_cnt=0.
  - turn_cnt increments per tick.
  - On the tick where turn_cnt == TURN_FRAMES-1: toggle facing_left and go to WALK_L if the new facing_left=1, else WALK_R.
- Hit handling:
  - hit=1 on any clk cycle (tick not required) while in WALK_* or TURN: next state STUN, stun_cnt=0, stunned=1, anim_frame=0.
  - Resulting stunned=1 is visible the cycle after hit.
  - facing_left is unchanged; an in-progress TURN is abandoned.
- STUN:
  - pos_x frozen.
  - stun_cnt increments per tick.
  - hit=1 while in STUN restarts stun_cnt=0.
  - On the tick where stun_cnt == STUN_FRAMES-1: stunned=0, go to WALK_L if facing_left, else WALK_R.
  - If the sprite sits at a limit, the next walk tick re-enters TURN.
- Simultaneous events:
  - hit and frame_tick in the same cycle: hit wins; no movement or animation step on that tick.
  - rst overrides everything.
- Latency:
  - Outputs change only on the clk edge carrying frame_tick (or a hit).
  - All outputs are stable throughout the active video region.

Test Plan:
- Reset, then run 3 frames with enable=1 → frame_tick pulses once per frame (width 1 clk); pos_x = 0→2→4→6; facing_left=0.
- Force pos_x near the edge (START_X=604): tick 1 → pos_x=606; tick 2 → pos_x=608 and TURN; hold 16 ticks with pos_x=608, anim_frame=0 → facing_left=1; next tick → pos_x=606.
- Walk 8 ticks from reset → anim_frame steps 0→1 on tick 8; after 32 ticks anim_frame=0 (wrap from 3).
- Pulse hit for 1 clk mid-walk at pos_x=100 → stunned=1 next clk; pos_x stays 100 for 60 ticks; a second hit at stun tick 30 extends the freeze to 90 total ticks; then walking resumes in the same direction.
- hit asserted in the same cycle as frame_tick → no pos_x change that tick; STUN is entered.
- Assert rst during TURN (turn_cnt=7) → next clk: pos_x=START_X, facing_left=0, anim_frame=0, stunned=0, WALK_R; enable=0 for 5 frames → pos_x is unchanged while frame_tick still pulses.
